// File: rtl/dut_mem_pkg.sv
// Shared state type and default sizing for the dutMem responder slice.
package dut_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        TURN
    } state_t;

    localparam int unsigned DUTMEM_ADDR_W = 8;
    localparam int unsigned DUTMEM_DATA_W = 16;
    localparam int unsigned DUTMEM_DEPTH  = 256;
    localparam int unsigned DUTMEM_WAIT   = 2;

endpackage

// File: rtl/dut_mem_array.sv
// Single-port synchronous RAM with registered read port that holds between reads.
// Accesses at or beyond MEM_DEPTH drop writes and read back zero.
module dut_mem_array #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    assign in_range = 32'(addr) < MEM_DEPTH;
    assign idx      = addr[IDX_W-1:0];

    // Contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= in_range ? mem[idx] : '0;
        end
    end

endmodule

// File: rtl/dut_mem_responder.sv
// Responder end of the dutMem sel/wr_rd/addr/wdata -> rdata/ready protocol.
// Define DUTMEM_ADDR_ERR_EN to add the err output flagging out-of-range accesses.
module dut_mem_responder
    import dut_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DUTMEM_ADDR_W,
    parameter int unsigned DATA_WIDTH  = DUTMEM_DATA_W,
    parameter int unsigned MEM_DEPTH   = DUTMEM_DEPTH,
    parameter int unsigned WAIT_CYCLES = DUTMEM_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready
`ifdef DUTMEM_ADDR_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  lat_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  mem_we;
    logic                  mem_re;

    // RESP issues the array access so its registered result lands with ready.
    assign mem_we = (state == RESP) && lat_wr && !reset;
    assign mem_re = (state == RESP) && !lat_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel) begin
                        lat_wr    <= wr_rd;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    ready <= 1'b1;
                    state <= TURN;
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DUTMEM_ADDR_ERR_EN
    logic lat_oob;

    assign lat_oob = !(32'(lat_addr) < MEM_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= (state == RESP) && lat_oob;
        end
    end
`endif

    dut_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (rdata)
    );

endmodule

// File: doc/dut_mem_responder.md
Name: dut_mem_responder

Overview:
- Responder (memory) end of the dutMem sel/wr_rd/addr/wdata -> rdata/ready protocol. The existing testbench interface drives this protocol as initiator.
- Accepts single read/write requests, waits a parameterised number of cycles, then commits the write or returns read data with a one-cycle ready pulse.
- Sits behind the dutMem interface as the synthesizable DUT memory. Usable standalone or as a reusable slave model.

Parameters:
- ADDR_WIDTH, 8, address bus width.
- DATA_WIDTH, 16, data bus width.
- MEM_DEPTH, 256, number of words; must be <= 2**ADDR_WIDTH.
- WAIT_CYCLES, 2, wait states between accept and response; 0 allowed.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- sel  input  1  request valid, held by initiator until ready seen.
- wr_rd  input  1  1 = write, 0 = read.
- addr  input  ADDR_WIDTH  word address.
- wdata  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  read data, valid when ready=1 for a read.
- ready  output  1  one-cycle completion pulse.
- err  output  1  present only with DUTMEM_ADDR_ERR_EN; see Optional Feature.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - ready=0, rdata=0, err=0, state=IDLE, wait counter=0.
  - Memory array contents are not cleared.
- FSM states: IDLE, WAIT, RESP, TURN.
- IDLE: on a posedge with sel=1, latch addr, wr_rd and wdata. Go to WAIT with counter=WAIT_CYCLES, or go directly to RESP if WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 0. sel/addr/wdata changes are ignored; the latched request completes even if sel drops.
- RESP (lasts exactly one cycle, ready=1):
  - Write: the memory is updated with the latched wdata in this cycle; rdata is unchanged.
  - Read: rdata = mem[latched addr], driven registered together with ready.
  - Next state is TURN.
- TURN: one mandatory turnaround cycle with ready=0 and sel ignored. This absorbs the initiator's clocking-block sampling/output skew, under which sel is still high at the edge after ready. Next state is IDLE.
- Latency: sel sampled at edge N gives ready high in cycle N+WAIT_CYCLES+1. Minimum accept-to-accept spacing is WAIT_CYCLES+3 cycles.
- rdata holds the last read value until the next read completes or reset.
- Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.
- Reset mid-transaction: return to IDLE immediately and commit no write. ready=0 in the next cycle.
- Out-of-range address (addr >= MEM_DEPTH) without the feature: write dropped, read returns 0, normal ready timing.
- Read after write to the same address returns the new data; the write commits in RESP, before any later accept.

Optional Feature:
- Macro: DUTMEM_ADDR_ERR_EN.
- Defined:
  - err port exists.
  - err=1 together with ready on an out-of-range access; a write is dropped and rdata is forced to 0.
  - err=0 otherwise.
  - err is cleared by reset.
- Undefined: no err port; out-of-range handling as in Behaviour.

Decomposition:
- Package dut_mem_pkg:
  - state enum type (IDLE, WAIT, RESP, TURN);
  - default constants DUTMEM_ADDR_W=8, DUTMEM_DATA_W=16, DUTMEM_DEPTH=256, DUTMEM_WAIT=2.
- Sub-module dut_mem_array: single-port synchronous RAM.
  - Inputs: we, addr, wdata. Output: registered rdata.
  - Instantiated once. The FSM and latch registers live in dut_mem_responder.

Test Plan:
1. Reset, then write addr=0x10 data=0xBEEF with WAIT_CYCLES=2 -> ready high exactly 3 cycles after accept for 1 cycle; rdata stays 0.
2. Read addr=0x10 after test 1 -> ready at accept+3, rdata=0xBEEF in the same cycle; sel kept high one extra edge must not start a new transaction (TURN).
3. Back-to-back write 0x20=0x1234 then read 0x20, initiator reasserting sel right after TURN -> second accept at first-accept+5, read returns 0x1234.
4. WAIT_CYCLES=0 build: write then read addr=0xFF=0xA5A5 -> ready at accept+1, read returns 0xA5A5.
5. Assert reset during WAIT of a write to 0x30=0x5555 (0x30 previously written 0x1111) -> no ready pulse; subsequent read of 0x30 returns 0x1111.
6. MEM_DEPTH=128, addr=0x90: write 0x7777 then read. Without the macro: ready normal, rdata=0. With DUTMEM_ADDR_ERR_EN: err=1 with both ready pulses, rdata=0, in-range reads unaffected.
